// File: rtl/bank_axi3_mem_slave.sv
// bank_axi3_mem_slave
//   AXI3 responder for the bank BIU master port. Owns a MEM_DEPTH x 32B line
//   array, accepts AR/AW/W and returns R/B. One beat carries one full line;
//   beat k of a burst addresses line (start_idx + k) mod MEM_DEPTH.
//
//   Optional build macro: AXI3_SLV_RANGE_CHK_EN
//     defined   : bursts starting outside [MEM_BASE, MEM_BASE+MEM_DEPTH*32)
//                 return DECERR (rdata 0 / writes discarded, resp 2'b11)
//     undefined : upper address bits are ignored (aliasing), never DECERR
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   s_ar*  (valid/ready/id/addr/len)        read address channel
//   s_r*   (valid/ready/id/data/resp/last)  read data channel
//   s_aw*  (valid/ready/id/addr/len)        write address channel
//   s_w*   (valid/ready/data/strb/last)     write data channel
//   s_b*   (valid/ready/id/resp)            write response channel
module bank_axi3_mem_slave #(
   parameter int unsigned            ADDR_WIDTH = 32,
   parameter int unsigned            DATA_WIDTH = 256,
   parameter int unsigned            STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned            ID_WIDTH   = 8,
   parameter int unsigned            MEM_DEPTH  = 1024,
   parameter logic [ADDR_WIDTH-1:0]  MEM_BASE   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  s_arvalid_i,
   output logic                  s_arready_o,
   input  logic [ID_WIDTH-1:0]   s_arid_i,
   input  logic [ADDR_WIDTH-1:0] s_araddr_i,
   input  logic [3:0]            s_arlen_i,
   output logic                  s_rvalid_o,
   input  logic                  s_rready_i,
   output logic [ID_WIDTH-1:0]   s_rid_o,
   output logic [DATA_WIDTH-1:0] s_rdata_o,
   output logic [1:0]            s_rresp_o,
   output logic                  s_rlast_o,
   input  logic                  s_awvalid_i,
   output logic                  s_awready_o,
   input  logic [ID_WIDTH-1:0]   s_awid_i,
   input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
   input  logic [3:0]            s_awlen_i,
   input  logic                  s_wvalid_i,
   output logic                  s_wready_o,
   input  logic [DATA_WIDTH-1:0] s_wdata_i,
   input  logic [STRB_WIDTH-1:0] s_wstrb_i,
   input  logic                  s_wlast_i,
   output logic                  s_bvalid_o,
   input  logic                  s_bready_i,
   output logic [ID_WIDTH-1:0]   s_bid_o,
   output logic [1:0]            s_bresp_o
);

   localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

   typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   logic [IDX_W-1:0] ar_idx, aw_idx;
   logic             ar_dec, aw_dec;

   assign ar_idx = s_araddr_i[5 +: IDX_W];
   assign aw_idx = s_awaddr_i[5 +: IDX_W];

`ifdef AXI3_SLV_RANGE_CHK_EN
   // One extra bit so the window end cannot overflow at the top of the map.
   localparam logic [ADDR_WIDTH:0] RANGE_LO = {1'b0, MEM_BASE};
   localparam logic [ADDR_WIDTH:0] RANGE_HI = RANGE_LO + (ADDR_WIDTH+1)'(MEM_DEPTH * 32);

   assign ar_dec = ({1'b0, s_araddr_i} < RANGE_LO) || ({1'b0, s_araddr_i} >= RANGE_HI);
   assign aw_dec = ({1'b0, s_awaddr_i} < RANGE_LO) || ({1'b0, s_awaddr_i} >= RANGE_HI);
`else
   assign ar_dec = 1'b0;
   assign aw_dec = 1'b0;
`endif

   // Offset and (without range check) upper address bits carry no meaning.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{s_araddr_i, s_awaddr_i};

   // ---------------- read channel ----------------
   r_state_t         r_state;
   logic [IDX_W-1:0] r_idx;
   logic [3:0]       r_len, r_cnt;
   logic             r_dec;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= R_IDLE;
         s_arready_o <= 1'b0;
         s_rvalid_o  <= 1'b0;
         s_rid_o     <= '0;
         s_rdata_o   <= '0;
         s_rresp_o   <= '0;
         s_rlast_o   <= 1'b0;
         r_idx       <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_dec       <= 1'b0;
      end else begin
         unique case (r_state)
            R_IDLE: begin
               s_arready_o <= 1'b1;
               if (s_arvalid_i && s_arready_o) begin
                  s_arready_o <= 1'b0;
                  r_state     <= R_DATA;
                  r_idx       <= ar_idx;
                  r_len       <= s_arlen_i;
                  r_cnt       <= '0;
                  r_dec       <= ar_dec;
                  s_rvalid_o  <= 1'b1;
                  s_rid_o     <= s_arid_i;
                  s_rdata_o   <= ar_dec ? '0 : mem[ar_idx];
                  s_rresp_o   <= ar_dec ? 2'b11 : 2'b00;
                  s_rlast_o   <= (s_arlen_i == 4'd0);
               end
            end
            R_DATA: begin
               // rvalid is always high here; outputs hold until rready.
               if (s_rready_i) begin
                  if (s_rlast_o) begin
                     r_state     <= R_IDLE;
                     s_rvalid_o  <= 1'b0;
                     s_arready_o <= 1'b1;
                  end else begin
                     r_cnt     <= r_cnt + 4'd1;
                     r_idx     <= r_idx + IDX_W'(1);
                     s_rdata_o <= r_dec ? '0 : mem[r_idx + IDX_W'(1)];
                     s_rlast_o <= ((r_cnt + 4'd1) == r_len);
                  end
               end
            end
         endcase
      end
   end

   // ---------------- write channel ----------------
   w_state_t         w_state;
   logic [IDX_W-1:0] w_idx;
   logic [3:0]       w_len, w_cnt;
   logic [ID_WIDTH-1:0] w_id;
   logic             w_err, w_dec;
   logic             w_fire, w_end, w_last_bad;

   assign w_fire     = (w_state == W_DATA) && s_wready_o && s_wvalid_i;
   assign w_end      = (w_cnt == w_len);
   assign w_last_bad = (s_wlast_i != w_end);

   // Array has no reset; a beat presented during reset is dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_fire && !w_dec) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (s_wstrb_i[b]) mem[w_idx][b*8 +: 8] <= s_wdata_i[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         w_state     <= W_IDLE;
         s_awready_o <= 1'b0;
         s_wready_o  <= 1'b0;
         s_bvalid_o  <= 1'b0;
         s_bid_o     <= '0;
         s_bresp_o   <= '0;
         w_idx       <= '0;
         w_len       <= '0;
         w_cnt       <= '0;
         w_id        <= '0;
         w_err       <= 1'b0;
         w_dec       <= 1'b0;
      end else begin
         unique case (w_state)
            W_IDLE: begin
               s_awready_o <= 1'b1;
               if (s_awvalid_i && s_awready_o) begin
                  s_awready_o <= 1'b0;
                  s_wready_o  <= 1'b1;
                  w_state     <= W_DATA;
                  w_id        <= s_awid_i;
                  w_idx       <= aw_idx;
                  w_len       <= s_awlen_i;
                  w_cnt       <= '0;
                  w_err       <= 1'b0;
                  w_dec       <= aw_dec;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  w_idx <= w_idx + IDX_W'(1);
                  w_cnt <= w_cnt + 4'd1;
                  // Beat count, not wlast, closes the burst.
                  if (w_end) begin
                     s_wready_o <= 1'b0;
                     s_bvalid_o <= 1'b1;
                     s_bid_o    <= w_id;
                     s_bresp_o  <= w_dec ? 2'b11 : ((w_err || w_last_bad) ? 2'b10 : 2'b00);
                     w_state    <= W_RESP;
                  end else if (w_last_bad) begin
                     w_err <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (s_bready_i) begin
                  s_bvalid_o  <= 1'b0;
                  s_awready_o <= 1'b1;
                  w_state     <= W_IDLE;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bank_axi3_mem_slave.sv
// Testbench for bank_axi3_mem_slave (MEM_DEPTH = 64). Inputs are driven and
// outputs sampled on the falling clock edge; expected R/B responses are
// queued when requests are issued and popped as the DUT responds.
module tb_bank_axi3_mem_slave;

   localparam int unsigned DEPTH = 64;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         s_arvalid_i, s_arready_o;
   logic [7:0]   s_arid_i;
   logic [31:0]  s_araddr_i;
   logic [3:0]   s_arlen_i;
   logic         s_rvalid_o, s_rready_i;
   logic [7:0]   s_rid_o;
   logic [255:0] s_rdata_o;
   logic [1:0]   s_rresp_o;
   logic         s_rlast_o;
   logic         s_awvalid_i, s_awready_o;
   logic [7:0]   s_awid_i;
   logic [31:0]  s_awaddr_i;
   logic [3:0]   s_awlen_i;
   logic         s_wvalid_i, s_wready_o;
   logic [255:0] s_wdata_i;
   logic [31:0]  s_wstrb_i;
   logic         s_wlast_i;
   logic         s_bvalid_o, s_bready_i;
   logic [7:0]   s_bid_o;
   logic [1:0]   s_bresp_o;

   bank_axi3_mem_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (256),
      .ID_WIDTH   (8),
      .MEM_DEPTH  (DEPTH),
      .MEM_BASE   (32'h0)
   ) dut (
      .clk_i (clk_i), .rst_i (rst_i),
      .s_arvalid_i (s_arvalid_i), .s_arready_o (s_arready_o), .s_arid_i (s_arid_i),
      .s_araddr_i (s_araddr_i), .s_arlen_i (s_arlen_i),
      .s_rvalid_o (s_rvalid_o), .s_rready_i (s_rready_i), .s_rid_o (s_rid_o),
      .s_rdata_o (s_rdata_o), .s_rresp_o (s_rresp_o), .s_rlast_o (s_rlast_o),
      .s_awvalid_i (s_awvalid_i), .s_awready_o (s_awready_o), .s_awid_i (s_awid_i),
      .s_awaddr_i (s_awaddr_i), .s_awlen_i (s_awlen_i),
      .s_wvalid_i (s_wvalid_i), .s_wready_o (s_wready_o), .s_wdata_i (s_wdata_i),
      .s_wstrb_i (s_wstrb_i), .s_wlast_i (s_wlast_i),
      .s_bvalid_o (s_bvalid_o), .s_bready_i (s_bready_i), .s_bid_o (s_bid_o),
      .s_bresp_o (s_bresp_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0]   id;
      logic [255:0] data;
      logic [1:0]   resp;
      logic         last;
   } rexp_t;

   typedef struct {
      logic [7:0] id;
      logic [1:0] resp;
   } bexp_t;

   rexp_t        rq[$];
   bexp_t        bq[$];
   logic [255:0] model [DEPTH];
   int unsigned  n_cmp = 0;
   int unsigned  n_err = 0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int line_of(input logic [31:0] addr, input int k);
      logic [5:0] base;
      base = addr[10:5];
      return (int'(base) + k) % DEPTH;
   endfunction

   task automatic push_r(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input bit dec);
      for (int k = 0; k <= int'(len); k++) begin
         rexp_t e;
         e.id   = id;
         e.data = dec ? '0 : model[line_of(addr, k)];
         e.resp = dec ? 2'b11 : 2'b00;
         e.last = (k == int'(len));
         rq.push_back(e);
      end
   endtask

   task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input bit dec);
      int t = 0;
      push_r(id, addr, len, dec);
      s_arvalid_i = 1'b1; s_arid_i = id; s_araddr_i = addr; s_arlen_i = len;
      while (s_arready_o !== 1'b1 && t < 20) begin @(negedge clk_i); t++; end
      check("ar_ready", s_arready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      s_arvalid_i = 1'b0;
   endtask

   task automatic aw_hs(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
      int t = 0;
      s_awvalid_i = 1'b1; s_awid_i = id; s_awaddr_i = addr; s_awlen_i = len;
      while (s_awready_o !== 1'b1 && t < 20) begin @(negedge clk_i); t++; end
      check("aw_ready", s_awready_o, 1'b1);
      @(posedge clk_i);
      @(negedge clk_i);
      s_awvalid_i = 1'b0;
   endtask

   // Drive a W burst; call at a negedge after the AW handshake.
   task automatic w_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [31:0] strb, input logic [15:0] wmask, input bit dec);
      bit    err = 1'b0;
      bexp_t be;
      int    t;
      for (int k = 0; k <= int'(len); k++) begin
         logic [255:0] d;
         for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom();
         s_wvalid_i = 1'b1; s_wdata_i = d; s_wstrb_i = strb; s_wlast_i = wmask[k];
         t = 0;
         while (s_wready_o !== 1'b1 && t < 20) begin @(negedge clk_i); t++; end
         check("w_ready", s_wready_o, 1'b1);
         @(posedge clk_i);
         @(negedge clk_i);
         if (!dec) begin
            for (int b = 0; b < 32; b++)
               if (strb[b]) model[line_of(addr, k)][b*8 +: 8] = d[b*8 +: 8];
         end
         if (wmask[k] != (k == int'(len))) err = 1'b1;
      end
      s_wvalid_i = 1'b0; s_wlast_i = 1'b0;
      be.id   = id;
      be.resp = dec ? 2'b11 : (err ? 2'b10 : 2'b00);
      bq.push_back(be);
      check("b_valid_next_cycle", s_bvalid_o, 1'b1);
      t = 0;
      while (s_bvalid_o !== 1'b1 && t < 20) begin @(negedge clk_i); t++; end
      be = bq.pop_front();
      check("b_id", s_bid_o, be.id);
      check("b_resp", s_bresp_o, be.resp);
      s_bready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      s_bready_i = 1'b0;
      check("b_valid_drop", s_bvalid_o, 1'b0);
   endtask

   // Collect n beats; with toggle, rready alternates 1/0 per valid cycle.
   task automatic recv_r(input int n, input bit toggle);
      int           got = 0;
      int           t = 0;
      bit           stall = 1'b0;
      bit           ph = 1'b1;
      logic [255:0] held_d;
      logic         held_l;
      while (got < n && t < 200) begin
         if (s_rvalid_o === 1'b1) begin
            if (stall) begin
               check("r_hold_data", s_rdata_o, held_d);
               check("r_hold_last", s_rlast_o, held_l);
            end
            s_rready_i = toggle ? ph : 1'b1;
            ph = ~ph;
            if (s_rready_i) begin
               n_cmp++;
               assert (rq.size() > 0) else begin
                  n_err++;
                  $error("FAIL r_extra_beat observed=beat expected=none");
               end
               if (rq.size() > 0) begin
                  rexp_t e;
                  e = rq.pop_front();
                  check("r_data", s_rdata_o, e.data);
                  check("r_id", s_rid_o, e.id);
                  check("r_resp", s_rresp_o, e.resp);
                  check("r_last", s_rlast_o, e.last);
               end
               got++;
               stall = 1'b0;
            end else begin
               stall  = 1'b1;
               held_d = s_rdata_o;
               held_l = s_rlast_o;
            end
         end else begin
            s_rready_i = 1'b0;
         end
         @(negedge clk_i);
         t++;
      end
      s_rready_i = 1'b0;
      check("r_beat_count", got, n);
   endtask

   initial begin
      rst_i = 1'b1;
      s_arvalid_i = 1'b0; s_arid_i = '0; s_araddr_i = '0; s_arlen_i = '0;
      s_rready_i  = 1'b0;
      s_awvalid_i = 1'b0; s_awid_i = '0; s_awaddr_i = '0; s_awlen_i = '0;
      s_wvalid_i  = 1'b0; s_wdata_i = '0; s_wstrb_i = '0; s_wlast_i = 1'b0;
      s_bready_i  = 1'b0;

      // Reset: three cycles, all outputs low.
      repeat (3) @(negedge clk_i);
      check("rst_ctrl", {s_arready_o, s_rvalid_o, s_rid_o, s_rresp_o, s_rlast_o,
                         s_awready_o, s_wready_o, s_bvalid_o, s_bid_o, s_bresp_o}, '0);
      check("rst_rdata", s_rdata_o, '0);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", {s_arready_o, s_awready_o, s_rvalid_o, s_bvalid_o}, 4'b1100);

      // Single-beat write then read-back.
      aw_hs(8'h15, 32'h40, 4'd0);
      w_burst(8'h15, 32'h40, 4'd0, 32'hFFFF_FFFF, 16'h0001, 1'b0);
      send_ar(8'h01, 32'h40, 4'd0, 1'b0);
      check("r_latency", s_rvalid_o, 1'b1);
      recv_r(1, 1'b0);
      check("r_idle_after_last", s_rvalid_o, 1'b0);

      // Wrapping write then wrapping read with rready toggling.
      aw_hs(8'h20, 32'h7E0, 4'd3);
      w_burst(8'h20, 32'h7E0, 4'd3, 32'hFFFF_FFFF, 16'h0008, 1'b0);
      send_ar(8'h21, 32'h7E0, 4'd3, 1'b0);
      recv_r(4, 1'b1);

      // Early wlast: both beats still land, SLVERR reported.
      aw_hs(8'h33, 32'h100, 4'd1);
      w_burst(8'h33, 32'h100, 4'd1, 32'hFFFF_FFFF, 16'h0001, 1'b0);
      send_ar(8'h34, 32'h100, 4'd1, 1'b0);
      recv_r(2, 1'b0);

      // Concurrent AR/AW on the same line: read sees pre-write data.
      aw_hs(8'h40, 32'h120, 4'd0);
      w_burst(8'h40, 32'h120, 4'd0, 32'hFFFF_FFFF, 16'h0001, 1'b0);
      push_r(8'h41, 32'h120, 4'd0, 1'b0);
      s_arvalid_i = 1'b1; s_arid_i = 8'h41; s_araddr_i = 32'h120; s_arlen_i = 4'd0;
      s_awvalid_i = 1'b1; s_awid_i = 8'h42; s_awaddr_i = 32'h120; s_awlen_i = 4'd0;
      check("conc_ready", {s_arready_o, s_awready_o}, 2'b11);
      @(posedge clk_i);
      @(negedge clk_i);
      s_arvalid_i = 1'b0; s_awvalid_i = 1'b0;
      w_burst(8'h42, 32'h120, 4'd0, 32'h0000_000F, 16'h0001, 1'b0);
      recv_r(1, 1'b0);
      send_ar(8'h43, 32'h120, 4'd0, 1'b0);
      recv_r(1, 1'b0);

      // Reset in the middle of a read burst, then a normal read.
      send_ar(8'h50, 32'h7E0, 4'd3, 1'b0);
      recv_r(1, 1'b0);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("mid_rst_rvalid", {s_rvalid_o, s_arready_o}, 2'b00);
      rst_i = 1'b0;
      rq.delete();
      @(negedge clk_i);
      send_ar(8'h51, 32'h100, 4'd1, 1'b0);
      recv_r(2, 1'b0);

`ifdef AXI3_SLV_RANGE_CHK_EN
      // Out-of-window accesses decode-error; array left untouched.
      send_ar(8'h60, 32'h800, 4'd1, 1'b1);
      recv_r(2, 1'b0);
      aw_hs(8'h61, 32'h800, 4'd1);
      w_burst(8'h61, 32'h800, 4'd1, 32'hFFFF_FFFF, 16'h0001, 1'b1);
      send_ar(8'h62, 32'h0, 4'd1, 1'b0);
      recv_r(2, 1'b0);
`else
      // Without range checking the upper address bits alias.
      send_ar(8'h60, 32'h840, 4'd0, 1'b0);
      recv_r(1, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
